// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the sequential multiplier slice.
// The state encoding is fixed so that other units in the datapath can decode it.
package mul_seq_pkg;

  localparam int MUL_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul_step.sv
// One combinational add-shift step: conditionally add M into {C,A}, then shift {sum,Q} right by one.
// Kept separate so the divide unit can reuse the same datapath slice.
module mul_step #(
  parameter int W = 8
) (
  input  logic         c,
  input  logic [W-1:0] a,
  input  logic [W-1:0] q,
  input  logic [W-1:0] m,
  output logic [W-1:0] a_next,
  output logic [W-1:0] q_next
);

  logic [W:0] sum;

  assign sum    = {c, a} + (q[0] ? {1'b0, m} : '0);
  assign a_next = sum[W:1];

  // The low bit of the sum drops into the top of Q as Q shifts out its LSB.
  assign q_next[W-1] = sum[0];

  genvar gi;
  generate
    for (gi = 0; gi < W - 1; gi++) begin : g_qshift
      assign q_next[gi] = q[gi+1];
    end
  endgenerate

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential unsigned shift-add multiplier: accepts X/Y over valid/ready, runs W add-shift
// steps, then holds the 2W-bit product on a second valid/ready handshake.
module mul_seq_unit
  import mul_seq_pkg::*;
#(
  parameter int W = MUL_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     q_reg, q_next;
  logic [W-1:0]     m_reg, m_next;
  logic             c_reg, c_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [W-1:0]     step_a;
  logic [W-1:0]     step_q;

  // C is always zero between steps, so feeding it in keeps the sum at W+1 bits.
  mul_step #(.W(W)) u_step (
    .c      (c_reg),
    .a      (a_reg),
    .q      (q_reg),
    .m      (m_reg),
    .a_next (step_a),
    .q_next (step_q)
  );

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    q_next     = q_reg;
    m_next     = m_reg;
    c_next     = c_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        a_next   = step_a;
        q_next   = step_q;
        c_next   = 1'b0;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(W - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        // The unused encoding behaves exactly like IDLE.
        if (in_valid) begin
          m_next     = x;
          q_next     = y;
          a_next     = '0;
          c_next     = 1'b0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      q_reg     <= q_next;
      m_reg     <= m_next;
      c_reg     <= c_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Handshake outputs depend on registered state only.
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == RUN) || (state_reg == DONE);
  assign in_ready  = !busy;
  assign product   = {a_reg, q_reg};

endmodule

// File: tb/tb_mul_seq_unit.sv
// Scoreboard bench for mul_seq_unit at W=8 and W=4: expected products are queued on accept
// and compared when out_valid appears, along with latency, back-pressure and reset behaviour.
module tb_mul_seq_unit;

  logic        clk;
  logic        rst_b;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  x, y;
  logic [15:0] product;

  logic        v4_in_valid, v4_in_ready, v4_out_valid, v4_out_ready, v4_busy;
  logic [3:0]  v4_x, v4_y;
  logic [7:0]  v4_product;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  mul_seq_unit #(.W(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  mul_seq_unit #(.W(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .in_valid(v4_in_valid), .in_ready(v4_in_ready), .x(v4_x), .y(v4_y),
    .out_valid(v4_out_valid), .out_ready(v4_out_ready), .product(v4_product), .busy(v4_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Runs one W=8 operation; stall = cycles of out_ready low after out_valid rises.
  task automatic run8(input logic [7:0] xa, input logic [7:0] ya, input int stall);
    int cyc;
    logic [63:0] exp;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_ready", in_ready, 1);
    x = xa; y = ya; in_valid = 1'b1; out_ready = (stall == 0);
    sb_q.push_back(64'(xa) * 64'(ya));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("run_busy", busy, 1);
    chk("run_ready", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("latency8", cyc, 8);
    exp = sb_q.pop_front();
    chk("product8", product, exp);
    chk("done_ready", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; x = 8'd99; y = 8'd98;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_product", product, exp);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("cmpl_valid", out_valid, 0);
    chk("cmpl_ready", in_ready, 1);
    chk("cmpl_busy", busy, 0);
    $display("op W=8 x=%0d y=%0d stall=%0d product=%0d latency=%0d", xa, ya, stall, exp, cyc);
  endtask

  task automatic run4(input logic [3:0] xa, input logic [3:0] ya);
    int cyc;
    logic [63:0] exp;
    chk("v4_idle_ready", v4_in_ready, 1);
    v4_x = xa; v4_y = ya; v4_in_valid = 1'b1; v4_out_ready = 1'b1;
    sb_q.push_back(64'(xa) * 64'(ya));
    @(posedge clk); #1;
    v4_in_valid = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (!v4_out_valid && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("latency4", cyc, 4);
    exp = sb_q.pop_front();
    chk("product4", v4_product, exp);
    @(posedge clk);
    @(negedge clk);
    chk("v4_cmpl_ready", v4_in_ready, 1);
    $display("op W=4 x=%0d y=%0d product=%0d latency=%0d", xa, ya, exp, cyc);
  endtask

  initial begin
    rst_b = 1'b0;
    in_valid = 1'b0; x = '0; y = '0; out_ready = 1'b1;
    v4_in_valid = 1'b0; v4_x = '0; v4_y = '0; v4_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    rst_b = 1'b1;
    @(negedge clk);

    run8(8'd13, 8'd11, 0);
    run8(8'd255, 8'd255, 0);
    run8(8'd0, 8'd200, 0);
    run8(8'd200, 8'd0, 0);
    run8(8'd7, 8'd9, 5);
    for (int i = 0; i < 4; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i % 2);
    end

    // Reset in the middle of RUN: the in-flight product is discarded.
    x = 8'd200; y = 8'd100; in_valid = 1'b1;
    sb_q.push_back(64'd20000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_product", product, 0);
    sb_q.delete();
    $display("op W=8 x=200 y=100 reset at step 4, discarded");
    @(posedge clk); #3;
    rst_b = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    run8(8'd3, 8'd5, 0);

    run4(4'd15, 4'd15);
    run4(4'd9, 4'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
